// File: rtl/i2c_txn_sequencer_pkg.sv
// Shared command codes, state/error encodings and the pure next-state function
// of the I2C register-transaction sequencer.
package i2c_txn_sequencer_pkg;

  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_WRITE_CMD   = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_RESTART_CMD = 3'd4;
  localparam logic [2:0] k_STOP_CMD    = 3'd5;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } seq_err_t;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_REG, S_RESTART,
    S_DEV_R, S_WDATA, S_RDATA, S_STOP, S_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_WAIT_FIRST, PH_WAIT
  } seq_phase_t;

  // State reached when the command of state s completes (master back to ready).
  function automatic seq_state_t next_seq_state(seq_state_t s, logic rw,
                                                logic last, logic ack_err);
    seq_state_t n;
    n = S_IDLE;
    case (s)
      S_START:   n = S_DEV_W;
      S_DEV_W:   n = ack_err ? S_STOP : S_REG;
      S_REG:     n = ack_err ? S_STOP : (rw ? S_RESTART : S_WDATA);
      S_RESTART: n = S_DEV_R;
      S_DEV_R:   n = ack_err ? S_STOP : S_RDATA;
      S_WDATA:   n = (ack_err || last) ? S_STOP : S_WDATA;
      S_RDATA:   n = last ? S_STOP : S_RDATA;
      S_STOP:    n = S_DONE;
      default:   n = S_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] seq_cmd(seq_state_t s);
    logic [2:0] c;
    c = '0;
    case (s)
      S_START:                   c = k_START_CMD;
      S_DEV_W, S_REG, S_DEV_R,
      S_WDATA:                   c = k_WRITE_CMD;
      S_RESTART:                 c = k_RESTART_CMD;
      S_RDATA:                   c = k_READ_CMD;
      S_STOP:                    c = k_STOP_CMD;
      default:                   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_txn_sequencer.sv
// Register-level transaction controller driving the byte-level I2C master's
// command port: one request -> START/addr/reg/[RESTART/addr]/data.../STOP.
module i2c_txn_sequencer
  import i2c_txn_sequencer_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_rw,
  input  logic [6:0]       req_dev,
  input  logic [7:0]       req_reg,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic [1:0]       err,
  input  logic             m_ready,
  output logic             m_write,
  output logic [2:0]       m_cmd,
  output logic [7:0]       m_data,
  output logic             m_nack,
  input  logic [7:0]       m_rd_data,
  input  logic             m_ack_err
);

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  seq_state_t     state, nxt_state;
  seq_phase_t     phase;
  seq_err_t       err_pend;
  logic           rw_q;
  logic [6:0]     dev_q;
  logic [7:0]     reg_q;
  logic [LEN_W:0] byte_cnt;
  logic [15:0]    tmo_cnt;
  logic           last_byte, issue_ok, nack_hit;
  logic [7:0]     cmd_data;

  always_comb begin
    last_byte = (byte_cnt == '0);
    issue_ok  = m_ready && ((state != S_WDATA) || wr_valid);
    nack_hit  = m_ack_err && (state inside {S_DEV_W, S_REG, S_DEV_R, S_WDATA});
    nxt_state = next_seq_state(state, rw_q, last_byte, m_ack_err);
    cmd_data  = '0;
    case (state)
      S_DEV_W: cmd_data = {dev_q, 1'b0};
      S_REG:   cmd_data = reg_q;
      S_DEV_R: cmd_data = {dev_q, 1'b1};
      S_WDATA: cmd_data = wr_data;
      default: cmd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      phase     <= PH_ISSUE;
      err_pend  <= ERR_OK;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      byte_cnt  <= '0;
      tmo_cnt   <= '0;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      done      <= 1'b0;
      err       <= '0;
      m_write   <= 1'b0;
      m_cmd     <= '0;
      m_data    <= '0;
      m_nack    <= 1'b0;
    end else begin
      m_write  <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            rw_q      <= req_rw;
            dev_q     <= req_dev;
            reg_q     <= req_reg;
            byte_cnt  <= {1'b0, req_len};
            err_pend  <= ERR_OK;
            req_ready <= 1'b0;
            state     <= S_START;
            phase     <= PH_ISSUE;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          if (phase == PH_ISSUE) begin
            if (issue_ok) begin
              m_write  <= 1'b1;
              m_cmd    <= seq_cmd(state);
              m_data   <= cmd_data;
              m_nack   <= (state == S_RDATA) && last_byte;
              wr_ready <= (state == S_WDATA);
              tmo_cnt  <= '0;
              phase    <= PH_WAIT_FIRST;
            end
          // m_ready is stale on the first WAIT cycle (strobe still in flight)
          end else if (phase == PH_WAIT && m_ready) begin
            state <= nxt_state;
            phase <= PH_ISSUE;
            if (nack_hit)
              err_pend <= ERR_NACK;
            if (state inside {S_WDATA, S_RDATA})
              byte_cnt <= byte_cnt - CNT_ONE;
            if (state == S_RDATA) begin
              rd_valid <= 1'b1;
              rd_data  <= m_rd_data;
            end
            if (nxt_state == S_DONE) begin
              done <= 1'b1;
              err  <= err_pend;
            end
          end else if (tmo_cnt == TIMEOUT - 16'd1) begin
            state <= S_DONE;
            phase <= PH_ISSUE;
            done  <= 1'b1;
            err   <= ERR_TIMEOUT;
          end else begin
            phase   <= PH_WAIT;
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench for i2c_txn_sequencer with a behavioural I2C master model.
module tb_i2c_txn_sequencer;
  import i2c_txn_sequencer_pkg::*;

  localparam int unsigned LEN_W = 4;
  localparam logic [15:0] TMO   = 16'd20;

  logic clk, reset_n;
  logic req_valid, req_ready, req_rw;
  logic [6:0] req_dev;
  logic [7:0] req_reg;
  logic [LEN_W-1:0] req_len;
  logic wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic rd_valid;
  logic [7:0] rd_data;
  logic done;
  logic [1:0] err;
  logic m_ready, m_write, m_nack, m_ack_err;
  logic [2:0] m_cmd;
  logic [7:0] m_data, m_rd_data;

  i2c_txn_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .m_ready(m_ready), .m_write(m_write), .m_cmd(m_cmd), .m_data(m_data),
    .m_nack(m_nack), .m_rd_data(m_rd_data), .m_ack_err(m_ack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] exp_cmd_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [1:0]  exp_err_q[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  rd_src_q[$];

  int cyc = 0, n_done = 0, n_wr = 0, n_rd = 0;
  int last_mw_cyc = 0, done_cyc = 0;
  int stall_after = -1, stall_len = 0, stall_left = 0, stall_mw = 0;
  int cmd_idx = 0, nack_idx = -1, hang_idx = -1, m_delay = 0;
  logic [2:0] cur_cmd = '0;
  logic chk_rr = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic exp_cmd(input logic [2:0] c, input logic [7:0] d, input logic n);
    exp_cmd_q.push_back({c, d, n});
  endtask

  // Monitor, master model and write-data feeder, all sampled 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (chk_rr) begin
        check("req_ready_after_done", 32'(req_ready), 32'd1);
        check("done_pulse", 32'(done), 32'd0);
        chk_rr = 1'b0;
      end
      if (stall_left > 0 && m_write) stall_mw++;
      if (m_write) begin
        if (exp_cmd_q.size() == 0) check("cmd_extra", 32'(m_write), 32'd0);
        else check("cmd", 32'({m_cmd, m_data, m_nack}), 32'(exp_cmd_q.pop_front()));
        last_mw_cyc = cyc;
        cmd_idx++;
        cur_cmd   = m_cmd;
        m_ready   = 1'b0;
        m_ack_err = 1'b0;
        m_delay   = (cmd_idx == hang_idx) ? -1 : 3;
      end else if (m_delay > 0) begin
        m_delay--;
        if (m_delay == 0) begin
          m_ready   = 1'b1;
          m_ack_err = (cmd_idx == nack_idx);
          if (cur_cmd == k_READ_CMD && rd_src_q.size() > 0) m_rd_data = rd_src_q.pop_front();
        end
      end
      if (rd_valid) begin
        n_rd++;
        if (exp_rd_q.size() == 0) check("rd_extra", 32'(rd_valid), 32'd0);
        else check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        chk_rr   = 1'b1;
        if (exp_err_q.size() == 0) check("done_extra", 32'(done), 32'd0);
        else check("err", 32'(err), 32'(exp_err_q.pop_front()));
      end
      if (wr_ready) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        n_wr++;
        if (n_wr == stall_after) stall_left = stall_len;
      end else if (stall_left > 0) begin
        stall_left--;
      end
      wr_valid = (stall_left == 0) && (wr_q.size() > 0);
      wr_data  = (wr_q.size() > 0) ? wr_q[0] : 8'h00;
    end
  end

  task automatic start_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [LEN_W-1:0] len);
    @(posedge clk);
    #5;
    n_wr = 0;
    n_rd = 0;
    cmd_idx = 0;
    req_rw = rw; req_dev = dev; req_reg = rg; req_len = len;
    req_valid = 1'b1;
    @(posedge clk);
    #5;
    check("req_accept", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_wr);
    int start;
    start = n_done;
    for (int i = 0; i < 3000 && n_done == start; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #5;
    check("txn_done", 32'(n_done - start), 32'd1);
    check("wr_cnt", 32'(n_wr), 32'(exp_wr));
    check("cmd_left", 32'(exp_cmd_q.size()), 32'd0);
    check("rd_left", 32'(exp_rd_q.size()), 32'd0);
    wr_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_dev = '0; req_reg = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    m_ready = 1'b1; m_rd_data = '0; m_ack_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_outs", 32'({m_write, m_cmd, m_data, m_nack, wr_ready, rd_valid, done, err}), 32'd0);
    #4 reset_n = 1'b1;

    // Plain write, two bytes
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA0, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h10, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA5, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h5A, 1'b0); exp_cmd(k_STOP_CMD, 8'h00, 1'b0);
    exp_err_q.push_back(ERR_OK);
    wr_q = '{8'hA5, 8'h5A};
    start_req(1'b0, 7'h50, 8'h10, 4'd1);
    wait_done(2);

    // Read, three bytes, NACK on the last
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA0, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h20, 1'b0); exp_cmd(k_RESTART_CMD, 8'h00, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'hA1, 1'b0); exp_cmd(k_READ_CMD, 8'h00, 1'b0);
    exp_cmd(k_READ_CMD, 8'h00, 1'b0); exp_cmd(k_READ_CMD, 8'h00, 1'b1);
    exp_cmd(k_STOP_CMD, 8'h00, 1'b0);
    rd_src_q = '{8'h11, 8'h22, 8'h33};
    exp_rd_q = '{8'h11, 8'h22, 8'h33};
    exp_err_q.push_back(ERR_OK);
    start_req(1'b1, 7'h50, 8'h20, 4'd2);
    wait_done(0);
    check("rd_cnt", 32'(n_rd), 32'd3);

    // Device address NACK: straight to STOP, no data consumed
    nack_idx = 2;
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA0, 1'b0);
    exp_cmd(k_STOP_CMD, 8'h00, 1'b0);
    exp_err_q.push_back(ERR_NACK);
    wr_q = '{8'hC3, 8'h3C};
    start_req(1'b0, 7'h50, 8'h11, 4'd1);
    wait_done(0);
    nack_idx = -1;

    // Master never returns ready after REG: timeout, no STOP
    hang_idx = 3;
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA0, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h30, 1'b0);
    exp_err_q.push_back(ERR_TIMEOUT);
    wr_q = '{8'h77};
    start_req(1'b0, 7'h50, 8'h30, 4'd0);
    wait_done(0);
    check("tmo_latency", 32'(done_cyc - last_mw_cyc), 32'(TMO));
    hang_idx = -1;
    m_delay  = 0;
    m_ready  = 1'b1;

    // Write data stalls 100 cycles before byte 2; no timeout may fire
    stall_after = 1; stall_len = 100; stall_mw = 0;
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hA0, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h40, 1'b0); exp_cmd(k_WRITE_CMD, 8'h01, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h02, 1'b0); exp_cmd(k_WRITE_CMD, 8'h03, 1'b0);
    exp_cmd(k_STOP_CMD, 8'h00, 1'b0);
    exp_err_q.push_back(ERR_OK);
    wr_q = '{8'h01, 8'h02, 8'h03};
    start_req(1'b0, 7'h50, 8'h40, 4'd2);
    wait_done(3);
    check("stall_m_write", 32'(stall_mw), 32'd0);
    stall_after = -1;

    // Asynchronous reset in the middle of a read burst
    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'h54, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h05, 1'b0); exp_cmd(k_RESTART_CMD, 8'h00, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h55, 1'b0); exp_cmd(k_READ_CMD, 8'h00, 1'b0);
    exp_cmd(k_READ_CMD, 8'h00, 1'b0); exp_cmd(k_READ_CMD, 8'h00, 1'b0);
    exp_cmd(k_READ_CMD, 8'h00, 1'b1);
    rd_src_q = '{8'h9A, 8'h9B, 8'h9C, 8'h9D};
    exp_rd_q = '{8'h9A, 8'h9B, 8'h9C, 8'h9D};
    start_req(1'b1, 7'h2A, 8'h05, 4'd3);
    for (int i = 0; i < 500 && n_rd < 1; i++) begin
      @(posedge clk);
      #3;
    end
    check("rd_before_reset", 32'(n_rd), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_cmd_port", 32'({m_write, m_cmd, m_data, m_nack}), 32'd0);
    check("arst_rd", 32'({rd_valid, rd_data}), 32'd0);
    check("arst_misc", 32'({wr_ready, done, err}), 32'd0);
    exp_cmd_q.delete(); exp_rd_q.delete(); exp_err_q.delete();
    rd_src_q.delete(); wr_q.delete();
    m_delay = 0; m_ready = 1'b1; m_ack_err = 1'b0; chk_rr = 1'b0;
    repeat (2) @(posedge clk);
    #5 reset_n = 1'b1;

    exp_cmd(k_START_CMD, 8'h00, 1'b0); exp_cmd(k_WRITE_CMD, 8'hEE, 1'b0);
    exp_cmd(k_WRITE_CMD, 8'h7F, 1'b0); exp_cmd(k_WRITE_CMD, 8'hDE, 1'b0);
    exp_cmd(k_STOP_CMD, 8'h00, 1'b0);
    exp_err_q.push_back(ERR_OK);
    wr_q = '{8'hDE};
    start_req(1'b0, 7'h77, 8'h7F, 4'd0);
    wait_done(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
- Register-level transaction controller in front of the byte-level I2C master (START/WRITE/READ/RESTART/STOP command interface).
- Accepts one request: 7-bit device address, 8-bit register, 1..2^LEN_W data bytes, read or write.
- Issues the full command sequence to the master, streams data bytes in and out, and reports completion with an error code.
- Sits between the host/register-file logic and the I2C master; it is the only driver of the master's command port.

Parameters:
- LEN_W, 4, width of req_len; burst length = req_len+1 bytes (1..16).
- TIMEOUT, 16'd50000, clk cycles allowed for the master to return ready after a command.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when req_valid&req_ready
- req_rw  in  1  1=read, 0=write
- req_dev  in  7  target device address
- req_reg  in  8  register address
- req_len  in  LEN_W  byte count minus one
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed this cycle
- wr_data  in  8  write byte
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  8  read byte
- done  out  1  one-cycle pulse, transaction finished
- err  out  2  with done: 00 ok, 01 slave NACK, 10 timeout
- m_ready  in  1  master idle/accepting command
- m_write  out  1  command strobe, one cycle
- m_cmd  out  3  command code (k_*_CMD)
- m_data  out  8  byte for WRITE
- m_nack  out  1  master sends NACK after this READ
- m_rd_data  in  8  byte from last READ
- m_ack_err  in  1  slave NACKed last WRITE; valid when m_ready returns

Behaviour:
- Reset: req_ready=1; all other outputs 0; state IDLE; counters 0. Asserting reset_n low mid-transaction aborts immediately with no STOP. Bus recovery is the master's responsibility.
- Request capture: in IDLE with req_valid=1, latch the request fields, set req_ready=0 and go to START. Request fields are ignored outside IDLE.
- Write sequence: START, DEV_W (m_data={dev,0}), REG (m_data=reg), WDATA × (len+1), STOP, DONE.
- Read sequence: START, DEV_W, REG, RESTART, DEV_R (m_data={dev,1}), RDATA × (len+1), STOP, DONE.
- Every command state has two phases, ISSUE and WAIT.
- ISSUE: when m_ready=1, drive m_write=1 for exactly one cycle with m_cmd/m_data/m_nack, then enter WAIT.
- WAIT: ignore m_ready on the first WAIT cycle. Then wait for m_ready=1 and take the transition on that cycle.
- WDATA ISSUE additionally requires wr_valid=1. wr_ready pulses in the same cycle as m_write. While wr_valid=0 the state stalls indefinitely, and the timeout counter does not run.
- RDATA: m_nack=1 only on the last byte. On WAIT completion, rd_valid pulses for one cycle with rd_data=m_rd_data. There is no backpressure.
- NACK handling: on completion of DEV_W, REG, DEV_R or WDATA with m_ack_err=1, skip remaining bytes, go to STOP, and latch err=01. Later bytes are neither consumed (no wr_ready) nor produced.
- Timeout: a 16-bit counter clears on entering WAIT and increments each WAIT cycle. At TIMEOUT, go directly to DONE with err=10 and issue no STOP.
- Byte counter: LEN_W+1 bits, loaded with req_len, decremented per completed data byte. The last byte is detected at count==0. req_len=all-ones gives 2^LEN_W bytes without wrap.
- DONE: done=1 for one cycle with err. The next cycle returns to IDLE with req_ready=1. A new request may be accepted that cycle. err is held until the next done.

Decomposition:
- Command codes (k_START_CMD, k_WRITE_CMD, k_READ_CMD, k_RESTART_CMD, k_STOP_CMD) come from include/i2c.vh.
- State encodings and error codes go as localparams/defines in a new include/i2c_seq.vh.
- Next-state logic is written as a function in the same style as the master's next_* functions, so it can be unit-tested combinationally.
- No sub-module; the flat FSM plus two counters is natural.

Test Plan:
- Write, dev=7'h50, reg=8'h10, len=1, bytes A5,5A, master model ready after 3 cycles, no NACK -> m_cmd order START, WRITE A0, WRITE 10, WRITE A5, WRITE 5A, STOP; two wr_ready pulses; done with err=00.
- Read, dev=7'h50, reg=8'h20, len=2, model returns 11,22,33 -> START, WRITE A0, WRITE 20, RESTART, WRITE A1, READ×3 with m_nack=0,0,1, STOP; rd_valid ×3 with 11,22,33; err=00.
- Write where the model asserts m_ack_err on DEV_W -> next command STOP, no wr_ready, done err=01.
- Model holds m_ready=0 after REG with TIMEOUT=20 -> done err=10 after 20 WAIT cycles, no STOP issued, req_ready=1 the next cycle.
- Write with wr_valid low for 100 cycles before byte 2 -> no m_write during the stall, no timeout, normal completion.
- reset_n low during RDATA -> all outputs return to reset values asynchronously; after release, a fresh request completes correctly.
